// File: rtl/serial_comparator_ctrl.sv
// rtl/serial_comparator_ctrl.sv - bit-serial MSB-first magnitude comparator with IDLE/COMPARE/DONE control
// Operands are captured on the accepting edge and scanned one bit per clock from the top.
module serial_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             e
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;

  logic bit_a;
  logic bit_b;
  logic bits_differ;
  logic last_bit;

  logic capture;
  logic load_result;
  logic dec_idx;
  logic busy_d;
  logic done_d;

  assign bit_a       = a_q[idx];
  assign bit_b       = b_q[idx];
  assign bits_differ = bit_a ^ bit_b;
  assign last_bit    = (idx == '0);

  // State register plus every registered datapath/output bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= IDX_TOP;
      busy  <= 1'b0;
      done  <= 1'b0;
      g     <= 1'b0;
      l     <= 1'b0;
      e     <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_d;
      done  <= done_d;
      if (capture) begin
        a_q <= a;
        b_q <= b;
        idx <= IDX_TOP;
      end else if (dec_idx) begin
        idx <= idx - 1'b1;
      end
      if (load_result) begin
        g <= bit_a & ~bit_b;
        l <= ~bit_a & bit_b;
        e <= ~bits_differ;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COMPARE;
      COMPARE: if (bits_differ || last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy/done are computed from the next state so they leave the flops aligned with state.
  always_comb begin
    capture     = 1'b0;
    load_result = 1'b0;
    dec_idx     = 1'b0;
    busy_d      = (next_state == COMPARE) || (next_state == DONE);
    done_d      = (next_state == DONE);
    case (state)
      IDLE:    capture = start;
      COMPARE: begin
        load_result = bits_differ || last_bit;
        dec_idx     = !bits_differ && !last_bit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// tb/tb_serial_comparator_ctrl.sv - randomized self-checking bench for serial_comparator_ctrl
// Expected results come from integer comparison and a highest-differing-bit latency rule.
module tb_serial_comparator_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             g;
  logic             l;
  logic             e;

  int checks;
  int errors;

  serial_comparator_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .g     (g),
    .l     (l),
    .e     (e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edges from capture to the edge entering DONE: WIDTH - p for highest differing bit p.
  function automatic int latency_of(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] d;
    d = x ^ y;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (d[i]) return WIDTH - i;
    return WIDTH;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_compare(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input bit disturb);
    int lat;
    int edges;
    int busy_cnt;
    int extra_done;
    lat = latency_of(ta, tb);
    a = ta;
    b = tb;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < WIDTH + 4) begin
      if (disturb) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        start = (edges == 1);
      end
      tick();
      edges++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check("latency", edges, lat);
    check("done_seen", done, 1'b1);
    check("g", g, ta > tb);
    check("l", l, ta < tb);
    check("e", e, ta == tb);
    check("busy_cycles", busy_cnt, lat + 1);
    tick();
    check("done_pulse_width", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    if (disturb) begin
      extra_done = 0;
      repeat (WIDTH + 2) begin
        tick();
        if (done) extra_done++;
      end
      check("no_extra_done", extra_done, 0);
    end
  endtask

  typedef struct {
    int   done_edge;
    logic eg;
    logic el;
    logic ee;
  } exp_t;

  task automatic run_back_to_back();
    exp_t q[$];
    int   next_accept;
    int   t;
    int   results;
    exp_t x;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    next_accept = 0;
    results = 0;
    t = 0;
    while (t < 40 || (q.size() > 0 && t < 80)) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : (ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1)));
      a = ra;
      b = rb;
      start = (t < 40);
      if (start && t == next_accept) begin
        x.done_edge = t + latency_of(ra, rb);
        x.eg = ra > rb;
        x.el = ra < rb;
        x.ee = ra == rb;
        q.push_back(x);
        next_accept = x.done_edge + 2;
      end
      tick();
      if (q.size() > 0 && q[0].done_edge == t) begin
        x = q.pop_front();
        results++;
        check("b2b_done", done, 1'b1);
        check("b2b_glе", {g, l, e}, {x.eg, x.el, x.ee});
        check("b2b_onehot", 32'(g) + 32'(l) + 32'(e), 1);
      end else begin
        check("b2b_no_done", done, 1'b0);
      end
      t++;
    end
    start = 1'b0;
    check("b2b_drained", q.size(), 0);
    check("b2b_any_results", results > 1, 1'b1);
  endtask

  initial begin
    int done_cnt;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b1;
    a = '0;
    b = '0;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_gle", {g, l, e}, 3'b000);

    // First start accepted on the same edge that reset is released.
    rst_n = 1'b1;
    run_compare(8'hA5, 8'h25, 1'b0);
    run_compare(8'h3C, 8'h3D, 1'b0);
    run_compare(8'hFF, 8'hFF, 1'b0);
    run_compare(8'h00, 8'h00, 1'b0);
    run_compare(8'h81, 8'h80, 1'b1);
    repeat (6) run_compare(WIDTH'($urandom), WIDTH'($urandom), 1'b0);

    // Reset in the middle of a compare abandons it.
    a = 8'h01;
    b = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid_busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_gle", {g, l, e}, 3'b000);
    start = 1'b0;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      tick();
      if (done) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);

    run_back_to_back();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
